factory_test_gen: RTL and testbench



---
 rtl/factory_test_pkg.sv | 29 ++
 rtl/ft_reset_sync.sv | 41 ++++
 rtl/factory_test_gen.sv | 198 +++++++++++++++++++
 tb/tb_factory_test_gen.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/factory_test_pkg.sv
// -----------------------------------------------------------------------------
// factory_test_pkg
// Shared constants for the factory test pattern generator:
//   - mode_e       : encoding of ui_in[1:0] (which pattern source is shown)
//   - UI_*         : bit positions of the fields packed into ui_in
//   - DEFAULT_LFSR_TAPS : Galois feedback mask used by the 32-bit default build
// -----------------------------------------------------------------------------
package factory_test_pkg;

  // Pattern source selected onto the outputs.
  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,  // free-running up counter
    MODE_DN   = 2'b01,  // free-running down counter
    MODE_LFSR = 2'b10,  // Galois LFSR
    MODE_LOOP = 2'b11   // registered uio_in loopback (or edge counter)
  } mode_e;

  // Field layout of ui_in.
  localparam int UI_MODE_LSB = 0;
  localparam int UI_MODE_W   = 2;
  localparam int UI_BSEL_LSB = 2;
  localparam int UI_BSEL_W   = 3;
  localparam int UI_HOLD_BIT = 5;
  localparam int UI_OE_BIT   = 6;

  // Maximal-length feedback mask for the 32-bit LFSR.
  localparam logic [31:0] DEFAULT_LFSR_TAPS = 32'h8020_0003;

endpackage : factory_test_pkg

// File: rtl/ft_reset_sync.sv
// -----------------------------------------------------------------------------
// ft_reset_sync
// Reset synchroniser: asserts rst_i asynchronously with rst_n and releases it
// synchronously, SYNC_STAGES rising clk edges after rst_n rises.
//
// Parameters:
//   SYNC_STAGES - number of flops in the shift register (>= 2)
// Ports:
//   clk   in  clock
//   rst_n in  external reset, asynchronous, active-low
//   rst_i out internal reset, active-low, synchronous deassertion
// -----------------------------------------------------------------------------
module ft_reset_sync
  import factory_test_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_i
);

  // A 1 is shifted in from the bottom; rst_i follows the last stage.
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_i = sync_q[SYNC_STAGES-1];

endmodule : ft_reset_sync

// File: rtl/factory_test_gen.sv
// -----------------------------------------------------------------------------
// factory_test_gen
// Bring-up / silicon-test pattern generator for a tile. Three free-running
// sources (up counter, down counter, Galois LFSR) plus a registered loopback
// of uio_in run in parallel; ui_in picks which one is shown and which byte
// of it appears on uo_out. The low byte of the selected source can drive the
// bidirectional IOs.
//
// Build option:
//   FT_EDGE_CNT_EN - when defined, mode 11 shows an 8-bit counter of rising
//                    edges on uio_in[0] (behind a 2-flop synchroniser)
//                    instead of the registered loopback.
//
// Parameters:
//   CNT_W       - width of each source, multiple of 8, 16..64
//   SYNC_STAGES - flops in the internal reset synchroniser (>= 2)
//   LFSR_TAPS   - Galois feedback mask, CNT_W bits
//   LFSR_SEED   - LFSR reset value, non-zero
// Ports:
//   clk     in  clock
//   rst_n   in  asynchronous active-low reset
//   ena     in  design powered (unused)
//   ui_in   in  [1:0] mode, [4:2] byte select, [5] hold, [6] uio drive enable
//   uo_out  out selected byte; ui_in passthrough while rst_n is low
//   uio_in  in  loopback source
//   uio_out out low byte of the selected source
//   uio_oe  out bidirectional IO enable (all or nothing)
// -----------------------------------------------------------------------------
module factory_test_gen
  import factory_test_pkg::*;
#(
  parameter int               CNT_W       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0] LFSR_TAPS   = CNT_W'(DEFAULT_LFSR_TAPS),
  parameter logic [CNT_W-1:0] LFSR_SEED   = CNT_W'(1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int NBYTES = CNT_W / 8;

  // ---------------------------------------------------------------------------
  // Internal reset
  // ---------------------------------------------------------------------------
  logic rst_i;

  ft_reset_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rst_i (rst_i)
  );

  // ---------------------------------------------------------------------------
  // Control field decode
  // ---------------------------------------------------------------------------
  mode_e      mode;
  logic [2:0] bsel;
  logic       hold;
  logic       oe_req;

  assign mode   = mode_e'(ui_in[UI_MODE_LSB +: UI_MODE_W]);
  assign bsel   = ui_in[UI_BSEL_LSB +: UI_BSEL_W];
  assign hold   = ui_in[UI_HOLD_BIT];
  assign oe_req = ui_in[UI_OE_BIT];

  // ---------------------------------------------------------------------------
  // Pattern sources. All of them advance together; mode only picks the view.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_up_q, cnt_up_d;
  logic [CNT_W-1:0] cnt_dn_q, cnt_dn_d;
  logic [CNT_W-1:0] lfsr_q,   lfsr_d;

  always_comb begin
    cnt_up_d = cnt_up_q;
    cnt_dn_d = cnt_dn_q;
    lfsr_d   = lfsr_q;
    if (!hold) begin
      cnt_up_d = cnt_up_q + CNT_W'(1);
      cnt_dn_d = cnt_dn_q - CNT_W'(1);
      // Galois form: the bit shifted out decides whether taps are applied.
      lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      cnt_up_q <= '0;
      cnt_dn_q <= '0;
      lfsr_q   <= LFSR_SEED;
    end else begin
      cnt_up_q <= cnt_up_d;
      cnt_dn_q <= cnt_dn_d;
      lfsr_q   <= lfsr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Mode 11 source
  // ---------------------------------------------------------------------------
  logic [7:0] loop_src;
  logic       unused_ok;

`ifdef FT_EDGE_CNT_EN
  // uio_in[0] is asynchronous to clk: two flops before edge detection.
  logic [1:0] esync_q, esync_d;
  logic       eprev_q, eprev_d;
  logic [7:0] ecnt_q,  ecnt_d;
  logic       rise;

  assign rise = esync_q[1] & ~eprev_q;

  always_comb begin
    esync_d = {esync_q[0], uio_in[0]};
    eprev_d = esync_q[1];
    ecnt_d  = ecnt_q;
    if (rise && !hold) begin
      ecnt_d = ecnt_q + 8'd1;  // wraps 255 -> 0
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      esync_q <= '0;
      eprev_q <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      esync_q <= esync_d;
      eprev_q <= eprev_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign loop_src  = ecnt_q;
  assign unused_ok = &{1'b0, ena, ui_in[7], uio_in[7:1]};
`else
  // Loopback capture ignores hold so the pad path can always be observed.
  logic [7:0] loop_q, loop_d;

  always_comb begin
    loop_d = uio_in;
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      loop_q <= '0;
    end else begin
      loop_q <= loop_d;
    end
  end

  assign loop_src  = loop_q;
  assign unused_ok = &{1'b0, ena, ui_in[7]};
`endif

  // ---------------------------------------------------------------------------
  // Output selection (purely combinational from registers and ui_in)
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] sel_src;
  logic [7:0]       sel_byte;

  always_comb begin
    sel_src = '0;
    unique case (mode)
      MODE_UP:   sel_src = cnt_up_q;
      MODE_DN:   sel_src = cnt_dn_q;
      MODE_LFSR: sel_src = lfsr_q;
      MODE_LOOP: sel_src = {{(CNT_W-8){1'b0}}, loop_src};
      default:   sel_src = '0;
    endcase
  end

  // Byte selects beyond the source width fall through to zero.
  always_comb begin
    sel_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (bsel == 3'(i)) begin
        sel_byte = sel_src[i*8 +: 8];
      end
    end
  end

  // While rst_n is low the pads simply reflect ui_in, independent of clk.
  assign uo_out  = rst_n ? sel_byte : ui_in;
  assign uio_out = sel_src[7:0];

  // Never drive the pads in loopback mode: uio_in is the input there.
  assign uio_oe  = (rst_n && rst_i && oe_req && (mode != MODE_LOOP)) ? 8'hFF : 8'h00;

endmodule : factory_test_gen

// File: tb/tb_factory_test_gen.sv
// -----------------------------------------------------------------------------
// tb_factory_test_gen
// Self-checking bench for factory_test_gen (default CNT_W = 32). A behavioural
// model of the sources advances on every clock edge; expected outputs are
// pushed to a queue when inputs are driven and popped against the DUT on the
// falling edge. Honours FT_EDGE_CNT_EN for the mode 11 behaviour.
// -----------------------------------------------------------------------------
module tb_factory_test_gen;

  localparam int          CNT_W = 32;
  localparam int          SYNC  = 2;
  localparam logic [31:0] TAPS  = 32'h8020_0003;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  factory_test_gen #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];

  // Reference model of the sources
  logic [31:0] m_up, m_dn, m_lfsr;
  logic [7:0]  m_loop, m_ecnt;
  logic        m_s1, m_s2, m_prev;
  int          m_sync;
  logic        m_rsti;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_up   = '0;
    m_dn   = '0;
    m_lfsr = 32'h1;
    m_loop = '0;
    m_ecnt = '0;
    m_s1   = 1'b0;
    m_s2   = 1'b0;
    m_prev = 1'b0;
    m_sync = 0;
    m_rsti = 1'b0;
  endtask

  // Wait for a rising edge and advance the model with the inputs seen there.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_rsti) begin
        if (!ui_in[5]) begin
          m_up   = m_up + 32'd1;
          m_dn   = m_dn - 32'd1;
          m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ TAPS) : (m_lfsr >> 1);
          if (m_s2 && !m_prev) m_ecnt = m_ecnt + 8'd1;
        end
        m_loop = uio_in;
        m_prev = m_s2;
        m_s2   = m_s1;
        m_s1   = uio_in[0];
      end
      if (m_sync < SYNC) m_sync++;
      m_rsti = (m_sync >= SYNC);
    end
  endtask

  function automatic logic [23:0] model_out();
    logic [31:0] src;
    logic [7:0]  uo;
    logic [7:0]  oe;
    int          b;
    b = int'(ui_in[4:2]);
    case (ui_in[1:0])
      2'b00:   src = m_up;
      2'b01:   src = m_dn;
      2'b10:   src = m_lfsr;
`ifdef FT_EDGE_CNT_EN
      default: src = {24'h0, m_ecnt};
`else
      default: src = {24'h0, m_loop};
`endif
    endcase
    uo = (b >= CNT_W / 8) ? 8'h00 : 8'(src >> (b * 8));
    if (!rst_n) uo = ui_in;
    oe = (rst_n && m_rsti && ui_in[6] && (ui_in[1:0] != 2'b11)) ? 8'hFF : 8'h00;
    return {uo, src[7:0], oe};
  endfunction

  task automatic push_exp();
    exp_q.push_back(model_out());
  endtask

  task automatic pop_cmp(input string tag);
    logic [23:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_qempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_uo"},  {24'h0, uo_out},  {24'h0, e[23:16]});
      check_eq({tag, "_uio"}, {24'h0, uio_out}, {24'h0, e[15:8]});
      check_eq({tag, "_oe"},  {24'h0, uio_oe},  {24'h0, e[7:0]});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step_check(input string tag, input int n);
    repeat (n) begin
      tick();
      @(negedge clk);
      push_exp();
      pop_cmp(tag);
    end
  endtask

  // Change ui_in away from the rising edge and check the same-cycle effect.
  task automatic set_in(input string tag, input logic [7:0] v);
    ui_in = v;
    #1;
    push_exp();
    pop_cmp(tag);
  endtask

  // Read all four bytes of the LFSR within one low clock phase.
  task automatic read_lfsr(output logic [31:0] word);
    word = '0;
    for (int b = 0; b < 4; b++) begin
      ui_in = {3'b000, 3'(b), 2'b10};
      #1;
      word[b*8 +: 8] = uo_out;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] word;

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h5C;
    uio_in = 8'h00;
    model_reset();

    // Reset state and passthrough
    repeat (2) @(negedge clk);
    push_exp();
    pop_cmp("rst_pass");
    check_eq("rst_uo_const", {24'h0, uo_out}, 32'h5C);
    set_in("rst_pass2", 8'h42);
    check_eq("rst_oe_const", {24'h0, uio_oe}, 32'h0);

    // Release reset, count up
    ui_in = 8'h00;
    rst_n = 1'b1;
    step_check("sync_win", 1);
    step_check("up", SYNC + 9);
    check_eq("up_0a", {24'h0, uo_out}, 32'h0A);
    check_eq("up_oe0", {24'h0, uio_oe}, 32'h0);

    // Down counter and byte select
    set_in("dn_b3", 8'h0D);
    step_check("dn", 1);
    check_eq("dn_ff", {24'h0, uo_out}, 32'hFF);
    set_in("dn_b5", 8'h15);
    check_eq("dn_b5_zero", {24'h0, uo_out}, 32'h00);
    set_in("dn_b4", 8'h11);
    set_in("dn_b1", 8'h05);

    // Hold
    set_in("hold_on", 8'h20);
    step_check("hold", 20);

    // IO drive
    set_in("oe_up", 8'h40);
    check_eq("oe_ff", {24'h0, uio_oe}, 32'hFF);
    step_check("oe_track", 5);
    set_in("oe_loop", 8'h43);
    check_eq("oe_loop_zero", {24'h0, uio_oe}, 32'h0);
    set_in("pre_mid", 8'h40);
    step_check("pre_mid_run", 3);

    // Asynchronous reset mid-cycle
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("mid_uo", {24'h0, uo_out}, 32'h40);
    check_eq("mid_oe", {24'h0, uio_oe}, 32'h0);
    @(negedge clk);
    push_exp();
    pop_cmp("mid_rst");
    check_eq("mid_uio_zero", {24'h0, uio_out}, 32'h0);
    step_check("mid_hold_rst", 2);

    // LFSR from seed
    ui_in = 8'h02;
    rst_n = 1'b1;
    #1;
    push_exp();
    pop_cmp("lfsr_rel");
    step_check("lfsr_sync", SYNC + 1);
    read_lfsr(word);
    check_eq("lfsr_first", word, 32'h8020_0003);
    check_eq("lfsr_first_m", word, m_lfsr);

    for (int i = 0; i < 1000; i++) begin
      ui_in = {3'b000, 3'(i % 4), 2'b10};
      tick();
      @(negedge clk);
      push_exp();
      pop_cmp("lfsr_run");
      if (i % 100 == 99) begin
        read_lfsr(word);
        check_eq("lfsr_nz", {31'h0, (word != 32'h0)}, 32'h1);
        check_eq("lfsr_word", word, m_lfsr);
      end
    end

    // Mode 11 after a fresh reset
    rst_n  = 1'b0;
    model_reset();
    uio_in = 8'h00;
    ui_in  = 8'h03;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    step_check("loop_sync", SYNC);
`ifdef FT_EDGE_CNT_EN
    for (int p = 0; p < 3; p++) begin
      uio_in = 8'h01;
      step_check("ecnt_hi", 2);
      uio_in = 8'h00;
      step_check("ecnt_lo", 2);
    end
    step_check("ecnt_tail", 3);
    check_eq("ecnt_3", {24'h0, uo_out}, 32'h03);
    set_in("ecnt_b1", 8'h07);
`else
    uio_in = 8'hA5;
    #1;
    push_exp();
    pop_cmp("loop_pre");
    step_check("loop", 1);
    check_eq("loop_a5", {24'h0, uo_out}, 32'hA5);
    set_in("loop_b1", 8'h07);
    check_eq("loop_b1_zero", {24'h0, uo_out}, 32'h00);
    set_in("loop_hold", 8'h23);
    uio_in = 8'h3C;
    step_check("loop_hold_run", 1);
    check_eq("loop_3c", {24'h0, uo_out}, 32'h3C);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_factory_test_gen
